kpn_channel_fifo: RTL

KPN_CHANNEL_FIFO -- requirements
Module: kpn_channel_fifo

---
 rtl/kpn_fifo_pkg.sv | 18 +
 rtl/kpn_fifo_ram.sv | 27 ++
 rtl/kpn_channel_fifo.sv | 97 +++++++++
 3 files changed

// File: rtl/kpn_fifo_pkg.sv
// Shared defaults and transfer encoding for the KPN channel FIFO.
package kpn_fifo_pkg;

    localparam int KPN_DATA_WIDTH = 16;
    localparam int KPN_ADDR_BITS  = 5;
    localparam int KPN_DEPTH      = 1 << KPN_ADDR_BITS;
    localparam int KPN_AF_LEVEL   = KPN_DEPTH - 2;
    localparam int KPN_AE_LEVEL   = 2;

    // Accepted-transfer classification for one clock cycle: {write, read}.
    typedef enum logic [1:0] {
        XFER_IDLE = 2'b00,
        XFER_RD   = 2'b01,
        XFER_WR   = 2'b10,
        XFER_BOTH = 2'b11
    } xfer_e;

endpackage

// File: rtl/kpn_fifo_ram.sv
// Token storage: one synchronous write port and one registered read port, no reset.
module kpn_fifo_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_BITS  = 5
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_BITS-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_BITS-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

    // rdata holds its value between reads.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/kpn_channel_fifo.sv
// Single-clock KPN channel FIFO: pointers, occupancy count, flags and sticky errors.
module kpn_channel_fifo
    import kpn_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = KPN_DATA_WIDTH,
    parameter int ADDR_BITS  = KPN_ADDR_BITS,
    parameter int AF_LEVEL   = KPN_AF_LEVEL,
    parameter int AE_LEVEL   = KPN_AE_LEVEL
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] entry_1,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] output_1,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_BITS:0]    count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS:0] DEPTH_CNT = DEPTH[ADDR_BITS:0];
    localparam logic [ADDR_BITS:0] AF_CNT    = AF_LEVEL[ADDR_BITS:0];
    localparam logic [ADDR_BITS:0] AE_CNT    = AE_LEVEL[ADDR_BITS:0];

    logic [ADDR_BITS-1:0]  wr_ptr;
    logic [ADDR_BITS-1:0]  rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  out_loaded;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Flags come only from the count register; wr/rd never reach them.
    assign full         = (count == DEPTH_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    // A full FIFO rejects the write even when a read frees a slot; an empty one never bypasses.
    assign wr_acc = wr && !full;
    assign rd_acc = rd && !empty;

    kpn_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (ADDR_BITS)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (entry_1),
        .re    (rd_acc),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    // The RAM read register has no reset, so output_1 is forced to zero until the first read after reset.
    assign output_1 = out_loaded ? ram_rdata : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rd_valid   <= 1'b0;
            out_loaded <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_BITS'(1);
            end
            if (rd_acc) begin
                rd_ptr     <= rd_ptr + ADDR_BITS'(1);
                out_loaded <= 1'b1;
            end
            case (xfer_e'({wr_acc, rd_acc}))
                XFER_WR:   count <= count + (ADDR_BITS+1)'(1);
                XFER_RD:   count <= count - (ADDR_BITS+1)'(1);
                XFER_BOTH: count <= count;
                XFER_IDLE: count <= count;
            endcase
            if (wr && full) begin
                overflow <= 1'b1;
            end
            if (rd && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule
